cr16_uart_loader: RTL and testbench

- Upstream boot stage for the CR16 + BRAM system. Receives a program image over a UART (8N1) and writes it into BRAM port A starting at address 0.
- Holds the CR16 disabled (O_CPU_HOLD drives the processor enable low) until the image is fully written, then releases it.
- Replaces fixed clock-count gating with a deterministic load/release handshake.

---
 rtl/cr16_uart_loader.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_cr16_uart_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr16_uart_loader.sv
// rtl/cr16_uart_loader.sv - UART boot loader writing a length-prefixed image into BRAM port A
module cr16_uart_loader #(
    parameter int P_CLK_FREQ_HZ   = 50000000,
    parameter int P_BAUD_RATE     = 115200,
    parameter int P_DATA_WIDTH    = 16,
    parameter int P_ADDRESS_WIDTH = 16,
    parameter int P_MAX_WORDS     = 1024,
    parameter int P_TIMEOUT_CLKS  = 5000000
) (
    input  logic                       I_CLK,
    input  logic                       I_RESET,
    input  logic                       I_UART_RX,
    input  logic                       I_START,
    input  logic                       I_BYPASS,
    output logic [P_DATA_WIDTH-1:0]    O_MEM_DATA,
    output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
    output logic                       O_MEM_WRITE_ENABLE,
    output logic                       O_CPU_HOLD,
    output logic                       O_BUSY,
    output logic                       O_DONE,
    output logic [1:0]                 O_ERROR
);

    localparam int CLKS_PER_BIT = P_CLK_FREQ_HZ / P_BAUD_RATE;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int TW           = $clog2(P_TIMEOUT_CLKS + 1);

    localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] C_TMO_LAST  = TW'(P_TIMEOUT_CLKS - 1);

    localparam logic [1:0] E_NONE    = 2'b00;
    localparam logic [1:0] E_FRAME   = 2'b01;
    localparam logic [1:0] E_LENGTH  = 2'b10;
    localparam logic [1:0] E_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    // ---------------------------------------------------------------
    // RX front end
    // ---------------------------------------------------------------
    logic            rx_meta_q;
    logic            rx_sync_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            byte_valid;
    logic            frame_err;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= I_UART_RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver state register
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Receiver next state: mid-bit sampling, false-start rejection, stop check
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == C_HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == C_BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == C_BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Load sequencer
    // ---------------------------------------------------------------
    state_t                     state_q, state_d;
    logic [15:0]                len_q, len_d;
    logic [7:0]                 hi_q, hi_d;
    logic [P_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [P_DATA_WIDTH-1:0]    data_q, data_d;
    logic [1:0]                 err_q, err_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic                       in_load;
    logic [15:0]                len_new;
    logic                       last_word;

    assign in_load   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                       (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
    assign len_new   = {hi_q, rx_shift_q};
    assign last_word = ({16'd0, addr_q} + 32'd1) == {16'd0, len_q};

    // Sequencer state register
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= E_NONE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Sequencer next state: byte framing into words, error and timeout handling
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        tmo_d   = tmo_q;

        // idle-gap timer saturates at its last value; any received byte restarts it
        if (tmo_q != C_TMO_LAST) begin
            tmo_d = tmo_q + TW'(1);
        end
        if (byte_valid) begin
            tmo_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (I_START) begin
                    state_d = S_LEN_HI;
                    addr_d  = '0;
                    tmo_d   = '0;
                end else if (I_BYPASS) begin
                    state_d = S_DONE;
                end
            end
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: begin
                if (frame_err) begin
                    state_d = S_ERROR;
                    err_d   = E_FRAME;
                end else if (byte_valid) begin
                    case (state_q)
                        S_LEN_HI: begin
                            hi_d    = rx_shift_q;
                            state_d = S_LEN_LO;
                        end
                        S_LEN_LO: begin
                            len_d = len_new;
                            if (len_new == 16'd0) begin
                                state_d = S_DONE;
                            end else if ({16'd0, len_new} > 32'(P_MAX_WORDS)) begin
                                state_d = S_ERROR;
                                err_d   = E_LENGTH;
                            end else begin
                                state_d = S_DATA_HI;
                            end
                        end
                        S_DATA_HI: begin
                            hi_d    = rx_shift_q;
                            state_d = S_DATA_LO;
                        end
                        default: begin
                            data_d  = P_DATA_WIDTH'(len_new);
                            state_d = S_WRITE;
                        end
                    endcase
                end else if (tmo_q == C_TMO_LAST) begin
                    state_d = S_ERROR;
                    err_d   = E_TIMEOUT;
                end
            end
            S_WRITE: begin
                // the final word leaves the address on N-1 so it never passes the image end
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + P_ADDRESS_WIDTH'(1);
                    state_d = S_DATA_HI;
                end
            end
            S_DONE, S_ERROR: begin
                if (I_START) begin
                    state_d = S_LEN_HI;
                    addr_d  = '0;
                    tmo_d   = '0;
                    err_d   = E_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign O_MEM_DATA         = data_q;
    assign O_MEM_ADDRESS      = addr_q;
    assign O_MEM_WRITE_ENABLE = (state_q == S_WRITE);
    assign O_CPU_HOLD         = (state_q != S_DONE);
    assign O_BUSY             = in_load || (state_q == S_WRITE);
    assign O_DONE             = (state_q == S_DONE);
    assign O_ERROR            = err_q;

endmodule

// File: tb/tb_cr16_uart_loader.sv
// tb/tb_cr16_uart_loader.sv - randomized self-checking bench for cr16_uart_loader
module tb_cr16_uart_loader;

    localparam int CPB      = 10;
    localparam int MAXW     = 8;
    localparam int TMO      = 500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        start = 1'b0;
    logic        bypass = 1'b0;
    logic [15:0] mem_data;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    int n_chk = 0;
    int n_fail = 0;
    int wide_cnt = 0;
    logic prev_we = 1'b0;
    logic [31:0] wq[$];
    logic [15:0] img [16];

    cr16_uart_loader #(
        .P_CLK_FREQ_HZ(1000000),
        .P_BAUD_RATE(100000),
        .P_DATA_WIDTH(16),
        .P_ADDRESS_WIDTH(16),
        .P_MAX_WORDS(MAXW),
        .P_TIMEOUT_CLKS(TMO)
    ) dut (
        .I_CLK(clk),
        .I_RESET(rst),
        .I_UART_RX(rx),
        .I_START(start),
        .I_BYPASS(bypass),
        .O_MEM_DATA(mem_data),
        .O_MEM_ADDRESS(mem_addr),
        .O_MEM_WRITE_ENABLE(mem_we),
        .O_CPU_HOLD(cpu_hold),
        .O_BUSY(busy),
        .O_DONE(done),
        .O_ERROR(err)
    );

    always #5 clk = ~clk;

    // write monitor: logs every strobe cycle and counts strobes wider than one cycle
    always @(negedge clk) begin
        if (mem_we) begin
            wq.push_back({mem_addr, mem_data});
            if (prev_we) wide_cnt++;
        end
        prev_we = mem_we;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(CPB);
        end
        rx = stop_bit;
        cycles(CPB);
        rx = 1'b1;
        if (!stop_bit) cycles(CPB);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_data"}, 32'(mem_data), 32'd0);
    endtask

    // Sends a whole image: length word, then img[0..n-1] if the length is acceptable,
    // and checks the outcome against what the image format says should happen.
    task automatic run_image(input string tag, input int n, input int gap_max);
        int base;
        int nexp;
        base = wq.size();
        wide_cnt = 0;
        pulse_start();
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        send_byte(8'(n >> 8), 1'b1);
        cycles($urandom_range(0, gap_max));
        send_byte(8'(n), 1'b1);
        if (n > 0 && n <= MAXW) begin
            for (int k = 0; k < n; k++) begin
                cycles($urandom_range(0, gap_max));
                send_byte(img[k][15:8], 1'b1);
                cycles($urandom_range(0, gap_max));
                send_byte(img[k][7:0], 1'b1);
            end
        end
        cycles(3);
        nexp = (n > MAXW) ? 0 : n;
        chk({tag, "_nwrites"}, 32'(wq.size() - base), 32'(nexp));
        for (int k = 0; k < nexp && base + k < wq.size(); k++) begin
            chk($sformatf("%s_write%0d", tag, k), wq[base + k], {16'(k), img[k]});
        end
        chk({tag, "_strobe_width"}, 32'(wide_cnt), 32'd0);
        if (n > MAXW) begin
            chk({tag, "_err"}, 32'(err), 32'd2);
            chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
            chk({tag, "_done"}, 32'(done), 32'd0);
        end else begin
            chk({tag, "_done"}, 32'(done), 32'd1);
            chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
            chk({tag, "_err"}, 32'(err), 32'd0);
        end
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic randomize_image();
        for (int k = 0; k < 16; k++) img[k] = 16'($urandom);
    endtask

    initial begin
        int base;
        int waited;

        // reset held for two cycles
        rst = 1'b1;
        cycles(2);
        check_reset_values("reset");
        rst = 1'b0;
        cycles(2);

        // directed normal load 00 02 12 34 AB CD
        img[0] = 16'h1234;
        img[1] = 16'hABCD;
        run_image("normal", 2, 0);

        // randomized images, including the largest accepted length
        randomize_image();
        run_image("rand_max", MAXW, 20);
        for (int r = 0; r < 3; r++) begin
            randomize_image();
            run_image($sformatf("rand%0d", r), $urandom_range(1, MAXW - 1), 30);
        end

        // zero-length image
        run_image("zero_len", 0, 5);

        // length overflow, then recovery with a valid image
        run_image("overflow", MAXW + 1, 5);
        randomize_image();
        run_image("recover", $urandom_range(1, MAXW), 10);

        // bad stop bit while waiting for a data high byte
        base = wq.size();
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        cycles(3);
        chk("frame_err", 32'(err), 32'd1);
        chk("frame_hold", 32'(cpu_hold), 32'd1);
        chk("frame_busy", 32'(busy), 32'd0);
        chk("frame_nwrites", 32'(wq.size() - base), 32'd0);

        // short low glitch in S_LEN_HI must not be taken as a byte
        base = wq.size();
        pulse_start();
        chk("glitch_err_cleared", 32'(err), 32'd0);
        rx = 1'b0;
        cycles(3);
        rx = 1'b1;
        cycles(30);
        chk("glitch_busy", 32'(busy), 32'd1);
        chk("glitch_err", 32'(err), 32'd0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hC3, 1'b1);
        send_byte(8'h5A, 1'b1);
        cycles(3);
        chk("glitch_nwrites", 32'(wq.size() - base), 32'd1);
        if (wq.size() > base) chk("glitch_write", wq[base], {16'd0, 16'hC35A});
        chk("glitch_done", 32'(done), 32'd1);

        // timeout after a single length byte
        pulse_start();
        send_byte(8'h00, 1'b1);
        waited = 0;
        while (err == 2'b00 && waited < TMO + 200) begin
            cycles(1);
            waited++;
        end
        chk("timeout_err", 32'(err), 32'd3);
        chk("timeout_not_early", 32'(waited >= TMO - 100), 32'd1);
        chk("timeout_hold", 32'(cpu_hold), 32'd1);
        chk("timeout_busy", 32'(busy), 32'd0);

        // bypass straight out of reset
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        chk("bypass_pre_done", 32'(done), 32'd0);
        bypass = 1'b1;
        cycles(1);
        bypass = 1'b0;
        chk("bypass_done", 32'(done), 32'd1);
        chk("bypass_hold", 32'(cpu_hold), 32'd0);

        // reset in the middle of word 1
        base = wq.size();
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        chk("midreset_word0", 32'(wq.size() - base), 32'd1);
        rst = 1'b1;
        cycles(1);
        check_reset_values("midreset");
        rst = 1'b0;
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        cycles(3);
        chk("midreset_no_more_writes", 32'(wq.size() - base), 32'd1);
        chk("midreset_idle_hold", 32'(cpu_hold), 32'd1);
        chk("midreset_idle_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
